fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/fetch_stage_ifid_reg.sv | 54 +++++
 rtl/fetch_stage.sv | 100 ++++++++++
 tb/tb_fetch_stage.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: instruction width, reset fetch address, NOP encoding
// and the IF/ID register update operations.
package fetch_stage_pkg;

    localparam int unsigned XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [1:0] {
        IFID_HOLD    = 2'd0,
        IFID_BUBBLE  = 2'd1,
        IFID_CAPTURE = 2'd2
    } ifid_op_e;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: holds, injects a NOP bubble, or captures a fetched word.
module ifid_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  op_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pcplus_i,
    output logic [31:0] instr_o,
    output logic [31:0] pcplus_o,
    output logic        valid_o
);

    logic [31:0] instr_q,  instr_d;
    logic [31:0] pcplus_q, pcplus_d;
    logic        valid_q,  valid_d;

    always_comb begin
        instr_d  = instr_q;
        pcplus_d = pcplus_q;
        valid_d  = valid_q;
        case (op_i)
            IFID_CAPTURE: begin
                instr_d  = instr_i;
                pcplus_d = pcplus_i;
                valid_d  = 1'b1;
            end
            // A bubble keeps PC+4 so downstream debug still sees the last real PC.
            IFID_BUBBLE: begin
                instr_d = INSTR_NOP;
                valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q  <= INSTR_NOP;
            pcplus_q <= 32'h0000_0000;
            valid_q  <= 1'b0;
        end else begin
            instr_q  <= instr_d;
            pcplus_q <= pcplus_d;
            valid_q  <= valid_d;
        end
    end

    assign instr_o  = instr_q;
    assign pcplus_o = pcplus_q;
    assign valid_o  = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, one-entry redirect buffer and the IF/ID register.
// The PC only advances when memory returns a word and the hazard unit is not holding it.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        pcsrcD,
    input  logic        jumpD,
    input  logic [31:0] PCbranchD,
    input  logic [31:0] PCjmpD,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] PCF,
    output logic [31:0] instrD,
    output logic [31:0] PCplusD,
    output logic        validD,
    output logic        redirect_pending
);

    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;

    logic        fire;
    logic        redir_accept;
    logic [31:0] redir_tgt;
    logic [31:0] pc_plus4;
    logic [1:0]  ifid_op;

    assign fire         = imem_ready & ~stallF;
    assign redir_accept = validD & ~stallD & (pcsrcD | jumpD);
    assign redir_tgt    = jumpD ? PCjmpD : PCbranchD;
    assign pc_plus4     = pc_q + 32'd4;

    always_comb begin
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        if (fire) begin
            pend_d = 1'b0;
            if (redir_accept)
                pc_d = redir_tgt;
            else if (pend_q)
                pc_d = pend_tgt_q;
            else
                pc_d = pc_plus4;
        end else if (redir_accept) begin
            pend_d     = 1'b1;
            pend_tgt_d = redir_tgt;
        end
    end

    // The word returned alongside a redirect belongs to the wrong path, so it is dropped.
    always_comb begin
        ifid_op = IFID_BUBBLE;
        if (stallD)
            ifid_op = IFID_HOLD;
        else if (redir_accept || pend_q)
            ifid_op = IFID_BUBBLE;
        else if (fire)
            ifid_op = IFID_CAPTURE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            pend_q     <= 1'b0;
            pend_tgt_q <= 32'h0000_0000;
        end else begin
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    ifid_reg u_ifid_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_i     (ifid_op),
        .instr_i  (imem_rdata),
        .pcplus_i (pc_plus4),
        .instr_o  (instrD),
        .pcplus_o (PCplusD),
        .valid_o  (validD)
    );

    // A request is always outstanding once out of reset.
    assign imem_req         = rst_n;
    assign imem_addr        = pc_q;
    assign PCF              = pc_q;
    assign redirect_pending = pend_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed checks of fetch_stage: sequential fetch, memory wait, branch/jump redirect,
// buffered redirect, stalls, reset with a pending redirect and PC wrap.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stallF, stallD, pcsrcD, jumpD;
    logic [31:0] PCbranchD, PCjmpD, imem_rdata;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr, PCF, instrD, PCplusD;
    logic        validD, redirect_pending;

    int tests = 0;
    int fails = 0;

    fetch_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stallF           (stallF),
        .stallD           (stallD),
        .pcsrcD           (pcsrcD),
        .jumpD            (jumpD),
        .PCbranchD        (PCbranchD),
        .PCjmpD           (PCjmpD),
        .imem_rdata       (imem_rdata),
        .imem_ready       (imem_ready),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .PCF              (PCF),
        .instrD           (instrD),
        .PCplusD          (PCplusD),
        .validD           (validD),
        .redirect_pending (redirect_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stallF = 1'b0; stallD = 1'b0; pcsrcD = 1'b0; jumpD = 1'b0;
        PCbranchD = 32'h0; PCjmpD = 32'h0;
        imem_ready = 1'b1; imem_rdata = 32'h2008_0005;

        #3;
        check("rst_pcf",     PCF, 32'h0);
        check("rst_req",     {31'b0, imem_req}, 32'h0);
        check("rst_instr",   instrD, 32'h0);
        check("rst_pcplus",  PCplusD, 32'h0);
        check("rst_valid",   {31'b0, validD}, 32'h0);
        check("rst_pend",    {31'b0, redirect_pending}, 32'h0);
        tick(); tick();
        check("rst_hold_pcf", PCF, 32'h0);

        rst_n = 1'b1;
        #1;
        check("rel_req", {31'b0, imem_req}, 32'h1);
        tick();
        check("seq_pcf4",    PCF, 32'h4);
        check("seq_instr",   instrD, 32'h2008_0005);
        check("seq_pcplus",  PCplusD, 32'h4);
        check("seq_valid",   {31'b0, validD}, 32'h1);
        tick();
        check("seq_pcf8",    PCF, 32'h8);

        // memory wait at PCF=8
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_addr",  imem_addr, 32'h8);
            check("wait_valid", {31'b0, validD}, 32'h0);
        end
        check("wait_pcplus", PCplusD, 32'h8);
        imem_ready = 1'b1; imem_rdata = 32'h1111_1111;
        tick();
        check("wait_pcf",    PCF, 32'hC);
        check("wait_instr",  instrD, 32'h1111_1111);
        check("wait_pcplus12", PCplusD, 32'hC);

        // taken branch
        pcsrcD = 1'b1; PCbranchD = 32'h40; imem_rdata = 32'hDEAD_BEEF;
        tick();
        check("br_pcf",      PCF, 32'h40);
        check("br_valid",    {31'b0, validD}, 32'h0);
        check("br_instr",    instrD, 32'h0);
        check("br_pcplus",   PCplusD, 32'hC);
        pcsrcD = 1'b0; imem_rdata = 32'h2222_2222;
        tick();
        check("br_tgt_pcf",   PCF, 32'h44);
        check("br_tgt_instr", instrD, 32'h2222_2222);
        check("br_tgt_pcplus", PCplusD, 32'h44);

        // jump has priority over branch
        jumpD = 1'b1; pcsrcD = 1'b1; PCjmpD = 32'h100; imem_rdata = 32'hBAD0_BAD0;
        tick();
        check("jmp_pcf",     PCF, 32'h100);
        check("jmp_valid",   {31'b0, validD}, 32'h0);
        jumpD = 1'b0; pcsrcD = 1'b0; imem_rdata = 32'h3333_3333;
        tick();
        check("jmp_tgt_pcf",   PCF, 32'h104);
        check("jmp_tgt_instr", instrD, 32'h3333_3333);

        // redirect while memory busy is buffered
        pcsrcD = 1'b1; PCbranchD = 32'h80; imem_ready = 1'b0;
        tick();
        check("pend_set",    {31'b0, redirect_pending}, 32'h1);
        check("pend_pcf",    PCF, 32'h104);
        check("pend_valid",  {31'b0, validD}, 32'h0);
        pcsrcD = 1'b0;
        tick();
        check("pend_addr",   imem_addr, 32'h104);
        check("pend_keep",   {31'b0, redirect_pending}, 32'h1);
        imem_ready = 1'b1; imem_rdata = 32'hBADB_AD00;
        tick();
        check("pend_apply_pcf",   PCF, 32'h80);
        check("pend_clear",       {31'b0, redirect_pending}, 32'h0);
        check("pend_squash_v",    {31'b0, validD}, 32'h0);
        check("pend_squash_i",    instrD, 32'h0);
        imem_rdata = 32'h4444_4444;
        tick();
        check("pend_tgt_pcf",    PCF, 32'h84);
        check("pend_tgt_instr",  instrD, 32'h4444_4444);
        check("pend_tgt_pcplus", PCplusD, 32'h84);

        // full stall
        stallF = 1'b1; stallD = 1'b1; imem_rdata = 32'h5555_5555;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_pcf",   PCF, 32'h84);
            check("stall_instr", instrD, 32'h4444_4444);
            check("stall_valid", {31'b0, validD}, 32'h1);
        end
        stallF = 1'b0; stallD = 1'b0;
        tick();
        check("unstall_pcf",   PCF, 32'h88);
        check("unstall_instr", instrD, 32'h5555_5555);

        // reset with a pending redirect
        pcsrcD = 1'b1; PCbranchD = 32'h200; imem_ready = 1'b0;
        tick();
        check("pend2_set", {31'b0, redirect_pending}, 32'h1);
        pcsrcD = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rst2_pcf",   PCF, 32'h0);
        check("rst2_pend",  {31'b0, redirect_pending}, 32'h0);
        check("rst2_valid", {31'b0, validD}, 32'h0);
        check("rst2_req",   {31'b0, imem_req}, 32'h0);
        tick();
        rst_n = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h6666_6666;
        tick();
        check("rst2_pcf4",   PCF, 32'h4);
        check("rst2_instr",  instrD, 32'h6666_6666);
        check("rst2_pcplus", PCplusD, 32'h4);

        // PC wrap at top of address space
        jumpD = 1'b1; PCjmpD = 32'hFFFF_FFFC;
        tick();
        check("wrap_pcf_top", PCF, 32'hFFFF_FFFC);
        jumpD = 1'b0; imem_rdata = 32'h7777_7777;
        tick();
        check("wrap_pcf",    PCF, 32'h0);
        check("wrap_pcplus", PCplusD, 32'h0);
        check("wrap_instr",  instrD, 32'h7777_7777);
        check("wrap_valid",  {31'b0, validD}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
